// File: rtl/byte_sub_shift_row.sv
// AES SubBytes + ShiftRows applied in place to the 16-word statemt memory.
// Define BSSR_INV_EN to build InvSubBytes + InvShiftRows for the decrypt chain.
module byte_sub_shift_row (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [4:0]  statemt_address0,
    output logic        statemt_ce0,
    output logic        statemt_we0,
    output logic [31:0] statemt_d0,
    input  logic [31:0] statemt_q0,
    output logic [4:0]  statemt_address1,
    output logic        statemt_ce1,
    output logic        statemt_we1,
    output logic [31:0] statemt_d1,
    input  logic [31:0] statemt_q1
);

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned BW      = 8;
    localparam int unsigned N_WORDS = 16;

`ifdef BSSR_INV_EN
    localparam logic [BW-1:0] SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`else
    localparam logic [BW-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDL,
        S_WR,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_k, w_k_nxt;
    logic [BW-1:0]   r_buf [N_WORDS];

    logic            r_done, w_done_nxt;
    logic            r_ce, w_ce_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_addr0, r_addr1, w_addr0_nxt, w_addr1_nxt;
    logic [DW-1:0]   r_d0, r_d1, w_d0_nxt, w_d1_nxt;
    logic [3:0]      w_src0, w_src1;
    logic            w_cap;
    logic [2:0]      w_cap_idx;
    logic            w_unused_q;

    // Source buffer slot for destination word a = r + 4c (row shift, 2-bit column wrap).
    function automatic logic [3:0] src_idx(input logic [3:0] a);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] col_src;
        row = a[1:0];
        col = a[3:2];
`ifdef BSSR_INV_EN
        col_src = col - row;
`else
        col_src = col + row;
`endif
        return {col_src, row};
    endfunction

    assign w_unused_q = ^{statemt_q0[DW-1:BW], statemt_q1[DW-1:BW]};

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        w_ce_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr0_nxt = '0;
        w_addr1_nxt = '0;
        w_d0_nxt    = '0;
        w_d1_nxt    = '0;
        w_src0      = '0;
        w_src1      = '0;

        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = S_RD;
                    w_k_nxt     = 3'd0;
                end
            end
            S_RD: begin
                w_k_nxt = r_k + 3'd1;
                if (r_k == 3'd7) w_state_nxt = S_RDL;
            end
            S_RDL: begin
                w_state_nxt = S_WR;
                w_k_nxt     = 3'd0;
            end
            S_WR: begin
                w_k_nxt = r_k + 3'd1;
                if (r_k == 3'd7) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 3'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        // The first write pair (words 0,1) never sources pair 7, which lands in the same edge.
        w_src0 = src_idx({w_k_nxt, 1'b0});
        w_src1 = src_idx({w_k_nxt, 1'b1});
        case (w_state_nxt)
            S_RD: begin
                w_ce_nxt    = 1'b1;
                w_addr0_nxt = {1'b0, w_k_nxt, 1'b0};
                w_addr1_nxt = {1'b0, w_k_nxt, 1'b1};
            end
            S_WR: begin
                w_ce_nxt    = 1'b1;
                w_we_nxt    = 1'b1;
                w_addr0_nxt = {1'b0, w_k_nxt, 1'b0};
                w_addr1_nxt = {1'b0, w_k_nxt, 1'b1};
                w_d0_nxt    = {24'h0, r_buf[w_src0]};
                w_d1_nxt    = {24'h0, r_buf[w_src1]};
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
            r_done  <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_d0    <= '0;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_done_nxt;
            r_ce    <= w_ce_nxt;
            r_we    <= w_we_nxt;
            r_addr0 <= w_addr0_nxt;
            r_addr1 <= w_addr1_nxt;
            r_d0    <= w_d0_nxt;
            r_d1    <= w_d1_nxt;
        end
    end

    // Read data returns one cycle after its address; k has already advanced (wraps to 0 in RDL).
    assign w_cap     = ((r_state == S_RD) && (r_k != 3'd0)) || (r_state == S_RDL);
    assign w_cap_idx = r_k - 3'd1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_buf <= '{default: '0};
        end else if (w_cap) begin
            r_buf[{w_cap_idx, 1'b0}] <= SBOX[statemt_q0[BW-1:0]];
            r_buf[{w_cap_idx, 1'b1}] <= SBOX[statemt_q1[BW-1:0]];
        end
    end

    assign ap_done          = r_done;
    assign ap_ready         = r_done;
    assign ap_idle          = (r_state == S_IDLE) && !ap_start;
    assign statemt_ce0      = r_ce;
    assign statemt_ce1      = r_ce;
    assign statemt_we0      = r_we;
    assign statemt_we1      = r_we;
    assign statemt_address0 = r_addr0;
    assign statemt_address1 = r_addr1;
    assign statemt_d0       = r_d0;
    assign statemt_d1       = r_d1;

endmodule

// File: tb/tb_byte_sub_shift_row.sv
// Directed bench for byte_sub_shift_row with a 1-cycle-latency dual-port memory model.
// Honours BSSR_INV_EN to exercise the inverse build.
module tb_byte_sub_shift_row;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  statemt_address0, statemt_address1;
    logic        statemt_ce0, statemt_ce1, statemt_we0, statemt_we1;
    logic [31:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [32];
    int          rd_cnt [16];
    int          wr_cnt [16];
    int          bad_addr;

    logic [7:0] fwd_vec [16] = '{8'h63, 8'h6b, 8'h67, 8'h76, 8'hf2, 8'h01, 8'hab, 8'h7b,
                                 8'h30, 8'hd7, 8'h77, 8'hc5, 8'hfe, 8'h7c, 8'h6f, 8'h2b};

`ifdef BSSR_INV_EN
    localparam logic [7:0] ZERO_OUT   = 8'h52;
    localparam logic [7:0] SECOND_OUT = 8'h48;
    localparam logic [7:0] UPPER_OUT  = 8'h50;
`else
    localparam logic [7:0] ZERO_OUT   = 8'h63;
    localparam logic [7:0] SECOND_OUT = 8'hfb;
    localparam logic [7:0] UPPER_OUT  = 8'hed;
`endif

    always #5 ap_clk = ~ap_clk;

    byte_sub_shift_row dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_we0      (statemt_we0),
        .statemt_d0       (statemt_d0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .statemt_q1       (statemt_q1)
    );

    // Memory model: read data valid the cycle after the address.
    always @(posedge ap_clk) begin
        if (statemt_ce0) begin
            if (statemt_address0[4]) bad_addr++;
            if (statemt_we0) begin
                mem[statemt_address0] = statemt_d0;
                wr_cnt[statemt_address0[3:0]]++;
            end else begin
                statemt_q0 <= mem[statemt_address0];
                rd_cnt[statemt_address0[3:0]]++;
            end
        end
        if (statemt_ce1) begin
            if (statemt_address1[4]) bad_addr++;
            if (statemt_we1) begin
                mem[statemt_address1] = statemt_d1;
                wr_cnt[statemt_address1[3:0]]++;
            end else begin
                statemt_q1 <= mem[statemt_address1];
                rd_cnt[statemt_address1[3:0]]++;
            end
        end
    end

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    // One start pulse, then observe 22 cycles against the expected ce/we schedule.
    task automatic do_run(output int done_cyc, output int n_done, output int bad_ctl, output int idle_hi);
        logic exp_ce, exp_we;
        done_cyc = 0; n_done = 0; bad_ctl = 0; idle_hi = 0; bad_addr = 0;
        for (int i = 0; i < 16; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; end
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(posedge ap_clk); #1;
            if (n == 1) ap_start = 1'b0;
            if (ap_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = n;
            end
            exp_ce = (n <= 8) || (n >= 10 && n <= 17);
            exp_we = (n >= 10 && n <= 17);
            if (statemt_ce0 !== exp_ce || statemt_ce1 !== exp_ce || statemt_we0 !== exp_we ||
                statemt_we1 !== exp_we || ap_ready !== ap_done) bad_ctl++;
            if (n <= 18 && ap_idle) idle_hi++;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        n_checks++;
        if ({ap_done, ap_ready, statemt_ce0, statemt_ce1, statemt_we0, statemt_we1} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000",
                     {ap_done, ap_ready, statemt_ce0, statemt_ce1, statemt_we0, statemt_we1});
        else n_pass++;
        n_checks++;
        if ({statemt_address0, statemt_address1, statemt_d0, statemt_d1} !== 74'h0)
            $display("FAIL reset_addr_data: got %h want 0",
                     {statemt_address0, statemt_address1, statemt_d0, statemt_d1});
        else n_pass++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        n_checks++;
        if (ap_idle !== 1'b1) $display("FAIL idle_after_reset: got %b want 1", ap_idle);
        else n_pass++;
        ap_start = 1'b1;
        #1;
        n_checks++;
        if (ap_idle !== 1'b0) $display("FAIL idle_with_start: got %b want 0", ap_idle);
        else n_pass++;
        ap_start = 1'b0;
        #1;
    endtask

    task automatic test_zeros();
        int dc, nd, bc, ih, bad;
        fill_mem(32'h0);
        do_run(dc, nd, bc, ih);
        n_checks++;
        if (dc !== 18) $display("FAIL zeros_done_cycle: got %0d want 18", dc); else n_pass++;
        n_checks++;
        if (nd !== 1) $display("FAIL zeros_done_count: got %0d want 1", nd); else n_pass++;
        n_checks++;
        if (bc !== 0) $display("FAIL zeros_ce_we_schedule: got %0d bad cycles want 0", bc); else n_pass++;
        n_checks++;
        if (ih !== 0) $display("FAIL zeros_idle_during_run: got %0d want 0", ih); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== {24'h0, ZERO_OUT}) $display("FAIL zeros_word%0d: got %h want %h", i, mem[i], {24'h0, ZERO_OUT});
            else n_pass++;
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_cnt[i] != 1 || wr_cnt[i] != 1) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL zeros_access_once: got %0d bad words want 0", bad); else n_pass++;
        n_checks++;
        if (bad_addr !== 0) $display("FAIL zeros_addr_bit4: got %0d want 0", bad_addr); else n_pass++;
    endtask

    task automatic test_pattern();
        int dc, nd, bc, ih;
`ifdef BSSR_INV_EN
        fill_mem(32'h0);
        for (int i = 0; i < 16; i++) mem[i] = {24'h0, fwd_vec[i]};
        do_run(dc, nd, bc, ih);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== 32'(i)) $display("FAIL inv_roundtrip_word%0d: got %h want %h", i, mem[i], 32'(i));
            else n_pass++;
        end
        fill_mem(32'h63);
        do_run(dc, nd, bc, ih);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== 32'h0) $display("FAIL inv_all63_word%0d: got %h want 0", i, mem[i]);
            else n_pass++;
        end
`else
        fill_mem(32'h0);
        for (int i = 0; i < 16; i++) mem[i] = 32'(i);
        do_run(dc, nd, bc, ih);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== {24'h0, fwd_vec[i]}) $display("FAIL ascend_word%0d: got %h want %h", i, mem[i], {24'h0, fwd_vec[i]});
            else n_pass++;
        end
`endif
        n_checks++;
        if (dc !== 18) $display("FAIL pattern_done_cycle: got %0d want 18", dc); else n_pass++;
    endtask

    task automatic test_upper_drop();
        int dc, nd, bc, ih;
        fill_mem(32'h0);
        mem[0] = 32'hFFFFFF53;
        do_run(dc, nd, bc, ih);
        n_checks++;
        if (mem[0] !== {24'h0, UPPER_OUT}) $display("FAIL upper_drop_word0: got %h want %h", mem[0], {24'h0, UPPER_OUT});
        else n_pass++;
        n_checks++;
        if (mem[5] !== {24'h0, ZERO_OUT}) $display("FAIL upper_drop_word5: got %h want %h", mem[5], {24'h0, ZERO_OUT});
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int dc, nd, bc, ih, n_done, n_idle;
        n_done = 0;
        fill_mem(32'h0);
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge ap_clk); #1;
            if (n == 1) ap_start = 1'b0;
            if (ap_done) n_done++;
        end
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, ap_done} !== 5'b0)
            $display("FAIL midrun_reset_ctl: got %b want 00000",
                     {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, ap_done});
        else n_pass++;
        n_checks++;
        if ({statemt_address0, statemt_d0} !== 37'h0)
            $display("FAIL midrun_reset_addr_data: got %h want 0", {statemt_address0, statemt_d0});
        else n_pass++;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_idle = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge ap_clk); #1;
            if (ap_done) n_done++;
            if (ap_idle) n_idle++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL midrun_no_done: got %0d want 0", n_done); else n_pass++;
        n_checks++;
        if (n_idle !== 25) $display("FAIL midrun_idle: got %0d want 25", n_idle); else n_pass++;
        n_checks++;
        if (mem[3] !== {24'h0, ZERO_OUT}) $display("FAIL midrun_partial_kept: got %h want %h", mem[3], {24'h0, ZERO_OUT});
        else n_pass++;
        n_checks++;
        if (mem[4] !== 32'h0) $display("FAIL midrun_unwritten: got %h want 0", mem[4]); else n_pass++;
        fill_mem(32'h0);
        do_run(dc, nd, bc, ih);
        n_checks++;
        if (dc !== 18 || nd !== 1) $display("FAIL restart_done: got cycle %0d count %0d want 18 1", dc, nd); else n_pass++;
        n_checks++;
        if (mem[15] !== {24'h0, ZERO_OUT}) $display("FAIL restart_word15: got %h want %h", mem[15], {24'h0, ZERO_OUT});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d1, d2, n_done, idle_hi;
        d1 = 0; d2 = 0; n_done = 0; idle_hi = 0;
        fill_mem(32'h0);
        @(negedge ap_clk);
        ap_start = 1'b1;
        #1;
        if (ap_idle) idle_hi++;
        for (int n = 1; n <= 42; n++) begin
            @(posedge ap_clk); #1;
            if (ap_done) begin
                n_done++;
                if (d1 == 0) d1 = n; else if (d2 == 0) d2 = n;
            end
            if (n <= 37 && ap_idle) idle_hi++;
            if (n == 19) begin
                n_checks++;
                if (statemt_ce0 !== 1'b0) $display("FAIL b2b_gap_ce: got %b want 0", statemt_ce0); else n_pass++;
            end
            if (n == 20) begin
                n_checks++;
                if ({statemt_ce0, statemt_we0, statemt_address0} !== 7'b1000000)
                    $display("FAIL b2b_second_read: got %b want 1000000", {statemt_ce0, statemt_we0, statemt_address0});
                else n_pass++;
            end
            if (n == 37) ap_start = 1'b0;
        end
        n_checks++;
        if (d1 !== 18 || d2 !== 37) $display("FAIL b2b_done_cycles: got %0d %0d want 18 37", d1, d2); else n_pass++;
        n_checks++;
        if (n_done !== 2) $display("FAIL b2b_done_count: got %0d want 2", n_done); else n_pass++;
        n_checks++;
        if (idle_hi !== 0) $display("FAIL b2b_idle: got %0d want 0", idle_hi); else n_pass++;
        n_checks++;
        if (mem[0] !== {24'h0, SECOND_OUT}) $display("FAIL b2b_word0: got %h want %h", mem[0], {24'h0, SECOND_OUT});
        else n_pass++;
        n_checks++;
        if (ap_idle !== 1'b1) $display("FAIL b2b_idle_after: got %b want 1", ap_idle); else n_pass++;
    endtask

    initial begin
        bad_addr = 0;
        test_reset();
        test_zeros();
        test_pattern();
        test_upper_drop();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
